alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 37 +++
 rtl/alu_sequencer_if.sv | 25 ++
 rtl/alu_sequencer.sv | 111 +++++++++++
 tb/tb_alu_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer.
//   op_mne        - 4-bit ALU operation mnemonics understood by the external ALU
//   seq_state_t   - sequencer FSM states (IDLE / EXEC / DONE)
//   FLAG_ONLY_MASK / is_flag_only
//                 - ops whose result only updates the flag; the accumulator holds
package alu_sequencer_pkg;

  typedef enum logic [3:0] {
    kPASS_A      = 4'h0,
    kPASS_B      = 4'h1,
    kADD         = 4'h2,
    kSUB         = 4'h3,
    kAND         = 4'h4,
    kOR          = 4'h5,
    kXOR         = 4'h6,
    kINC_A       = 4'h7,
    kDEC_A       = 4'h8,
    kSHIFT_LEFT  = 4'h9,
    kSHIFT_RIGHT = 4'hA,
    kA_IS_ZERO   = 4'hB,
    kPARALLEL    = 4'hC
  } op_mne;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // One bit per op code; a set bit marks an op that writes carry_flag only.
  localparam logic [15:0] FLAG_ONLY_MASK = (16'd1 << kA_IS_ZERO) | (16'd1 << kPARALLEL);

  function automatic logic is_flag_only(input logic [3:0] op);
    return FLAG_ONLY_MASK[op];
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction channel of the ALU sequencer.
//   instr_valid   - instruction offered (master -> slave)
//   instr_ready   - sequencer can accept (slave -> master)
//   instr_op      - ALU operation (op_mne encoding)
//   instr_operand - B operand used on every iteration
//   instr_repeat  - extra iterations (executes instr_repeat+1 times)
//   abort         - cancel the executing instruction
interface alu_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [7:0] instr_operand;
  logic [3:0] instr_repeat;
  logic       abort;

  modport master (
    output instr_valid, instr_op, instr_operand, instr_repeat, abort,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_operand, instr_repeat, abort,
    output instr_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one instruction at a time and drives an external
// combinational ALU for instr_repeat+1 cycles, folding each result back into
// the accumulator.
//   clk, reset_n            - clock, asynchronous active-low reset
//   instr (slave)           - instruction channel with abort
//   alu_op/alu_a/alu_b      - controls and operands to the external ALU
//   alu_out/alu_carry       - ALU results (combinational from alu_op/a/b)
//   acc, carry_flag         - accumulator and registered flag
//   busy                    - high in EXEC and DONE
//   done                    - one-cycle pulse when an instruction completes
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  alu_sequencer_if.slave    instr,
  output logic [3:0]        alu_op,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  input  logic [7:0]        alu_out,
  input  logic              alu_carry,
  output logic [7:0]        acc,
  output logic              carry_flag,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EXEC = EXEC;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0] state_reg,   state_next;
  logic [3:0] op_reg,      op_next;
  logic [7:0] operand_reg, operand_next;
  logic [3:0] count_reg,   count_next;
  logic [7:0] acc_reg,     acc_next;
  logic       carry_reg,   carry_next;

  logic in_exec;
  assign in_exec = (state_reg == S_EXEC);

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    operand_next = operand_reg;
    count_next   = count_reg;
    acc_next     = acc_reg;
    carry_next   = carry_reg;
    case (state_reg)
      S_IDLE: begin
        // abort is not looked at here: an instruction offered alongside it is taken.
        if (instr.instr_valid) begin
          op_next      = instr.instr_op;
          operand_next = instr.instr_operand;
          count_next   = instr.instr_repeat;
          state_next   = S_EXEC;
        end
      end
      S_EXEC: begin
        // The capture happens even on the aborting cycle.
        carry_next = alu_carry;
        if (!is_flag_only(op_reg)) begin
          acc_next = alu_out;
        end
        if (instr.abort) begin
          state_next = S_IDLE;
        end else if (count_reg != 4'd0) begin
          count_next = count_reg - 4'd1;
        end else begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      op_reg      <= kPASS_A;
      operand_reg <= 8'd0;
      count_reg   <= 4'd0;
      acc_reg     <= 8'd0;
      carry_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      operand_reg <= operand_next;
      count_reg   <= count_next;
      acc_reg     <= acc_next;
      carry_reg   <= carry_next;
    end
  end

  // Outside EXEC the ALU is parked on PASS_A with a zero B operand.
  assign alu_op = in_exec ? op_reg : kPASS_A;
  assign alu_a  = acc_reg;
  assign alu_b  = in_exec ? operand_reg : 8'd0;

  assign acc               = acc_reg;
  assign carry_flag        = carry_reg;
  assign instr.instr_ready = (state_reg == S_IDLE);
  assign busy              = (state_reg == S_EXEC) || (state_reg == S_DONE);
  assign done              = (state_reg == S_DONE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer; includes a behavioural ALU standing in
// for the parent-level ALU instance.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_out, acc;
  logic       alu_carry, carry_flag, busy, done;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr      (bus),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .acc        (acc),
    .carry_flag (carry_flag),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU. Flag-only ops drive a junk result so a wrongly updated acc shows.
  logic [8:0] alu_wide;
  always_comb begin
    alu_wide = {1'b0, alu_a};
    case (alu_op)
      kPASS_A:      alu_wide = {1'b0, alu_a};
      kPASS_B:      alu_wide = {1'b0, alu_b};
      kADD:         alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      kSUB:         alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
      kAND:         alu_wide = {1'b0, alu_a & alu_b};
      kOR:          alu_wide = {1'b0, alu_a | alu_b};
      kXOR:         alu_wide = {1'b0, alu_a ^ alu_b};
      kINC_A:       alu_wide = {1'b0, alu_a} + 9'd1;
      kDEC_A:       alu_wide = {1'b0, alu_a} - 9'd1;
      kSHIFT_LEFT:  alu_wide = {alu_a, 1'b0};
      kSHIFT_RIGHT: alu_wide = {alu_a[0], 1'b0, alu_a[7:1]};
      kA_IS_ZERO:   alu_wide = {(alu_a == 8'd0), 8'h55};
      kPARALLEL:    alu_wide = {^alu_a, 8'hAA};
      default:      alu_wide = 9'h1FF;
    endcase
    alu_out   = alu_wide[7:0];
    alu_carry = alu_wide[8];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction from IDLE and follow it to completion.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [7:0] operand,
                           input logic [3:0] rpt, input logic [7:0] exp_acc, input logic exp_c);
    int k;
    check({tag, " ready"}, 32'(bus.instr_ready), 32'd1);
    bus.instr_valid   = 1'b1;
    bus.instr_op      = op;
    bus.instr_operand = operand;
    bus.instr_repeat  = rpt;
    step();
    bus.instr_valid = 1'b0;
    k = 1;
    check({tag, " alu_op"}, 32'(alu_op), 32'(op));
    check({tag, " alu_b"}, 32'(alu_b), 32'(operand));
    while (!done && k < 40) begin
      step();
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'(rpt) + 32'd2);
    check({tag, " acc"}, 32'(acc), 32'(exp_acc));
    check({tag, " carry"}, 32'(carry_flag), 32'(exp_c));
    check({tag, " busy_in_done"}, 32'(busy), 32'd1);
    step();
    check({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] operand;
    logic [3:0] rpt;
    logic [7:0] exp_acc;
    logic       exp_c;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // Each vector starts from the acc/flag left by the previous one.
    vecs[0]  = '{kPASS_B,      8'h5A, 4'd0, 8'h5A, 1'b0};
    vecs[1]  = '{kSHIFT_LEFT,  8'h00, 4'd3, 8'hA0, 1'b1};  // B4,68,D0,A0
    vecs[2]  = '{kADD,         8'h70, 4'd1, 8'h80, 1'b0};  // A0+70=10 c1, 10+70=80 c0
    vecs[3]  = '{kSUB,         8'h01, 4'd0, 8'h7F, 1'b0};
    vecs[4]  = '{kPARALLEL,    8'h00, 4'd0, 8'h7F, 1'b1};  // odd parity of 7F
    vecs[5]  = '{kXOR,         8'hFF, 4'd0, 8'h80, 1'b0};
    vecs[6]  = '{kDEC_A,       8'h00, 4'd1, 8'h7E, 1'b0};
    vecs[7]  = '{kPASS_B,      8'h00, 4'd0, 8'h00, 1'b0};
    vecs[8]  = '{kA_IS_ZERO,   8'h00, 4'd0, 8'h00, 1'b1};
    vecs[9]  = '{kPASS_B,      8'h07, 4'd0, 8'h07, 1'b0};
    vecs[10] = '{kPARALLEL,    8'h00, 4'd0, 8'h07, 1'b1};
    vecs[11] = '{kA_IS_ZERO,   8'h00, 4'd0, 8'h07, 1'b0};
    vecs[12] = '{4'hE,         8'h00, 4'd0, 8'hFF, 1'b1};  // unknown op -> ALU default
    vecs[13] = '{kINC_A,       8'h00, 4'd0, 8'h00, 1'b1};  // FF+1 wraps
    vecs[14] = '{kSHIFT_RIGHT, 8'h00, 4'd0, 8'h00, 1'b0};
    vecs[15] = '{kOR,          8'h3C, 4'd0, 8'h3C, 1'b0};
    vecs[16] = '{kAND,         8'h0F, 4'd2, 8'h0C, 1'b0};

    bus.instr_valid   = 1'b0;
    bus.instr_op      = 4'h0;
    bus.instr_operand = 8'h00;
    bus.instr_repeat  = 4'h0;
    bus.abort         = 1'b0;
    reset_n           = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst acc", 32'(acc), 32'd0);
    check("rst carry", 32'(carry_flag), 32'd0);
    check("rst ready", 32'(bus.instr_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst alu_op", 32'(alu_op), 32'(kPASS_A));
    reset_n = 1'b1;
    step();
    check("idle alu_b", 32'(alu_b), 32'd0);

    for (int i = 0; i < 17; i++) begin
      run_instr($sformatf("v%0d", i), vecs[i].op, vecs[i].operand, vecs[i].rpt,
                vecs[i].exp_acc, vecs[i].exp_c);
    end

    // Abort in the third EXEC cycle of INC_A x16 from acc=00
    run_instr("abort_pre", kINC_A, 8'h00, 4'd0, 8'h0D, 1'b0);
    run_instr("abort_clr", kPASS_B, 8'h00, 4'd0, 8'h00, 1'b0);
    bus.instr_valid  = 1'b1;
    bus.instr_op     = kINC_A;
    bus.instr_repeat = 4'd15;
    step();
    bus.instr_valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      check($sformatf("abort done k%0d", k), 32'(done), 32'd0);
      step();
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort acc", 32'(acc), 32'h03);
    check("abort ready", 32'(bus.instr_ready), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort alu_op", 32'(alu_op), 32'(kPASS_A));
    step();
    check("abort hold acc", 32'(acc), 32'h03);
    check("abort hold done", 32'(done), 32'd0);

    // abort with instr_valid in IDLE still accepts; abort in DONE is ignored
    bus.abort         = 1'b1;
    bus.instr_valid   = 1'b1;
    bus.instr_op      = kPASS_B;
    bus.instr_operand = 8'h22;
    bus.instr_repeat  = 4'd0;
    step();
    bus.instr_valid = 1'b0;
    bus.abort       = 1'b0;
    check("idle_abort accepted", 32'(busy), 32'd1);
    step();
    check("idle_abort done", 32'(done), 32'd1);
    check("idle_abort acc", 32'(acc), 32'h22);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("done_abort ready", 32'(bus.instr_ready), 32'd1);
    check("done_abort acc", 32'(acc), 32'h22);

    // Reset after five EXEC cycles of INC_A x16
    bus.instr_valid  = 1'b1;
    bus.instr_op     = kINC_A;
    bus.instr_repeat = 4'd15;
    step();
    bus.instr_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rmid done k%0d", k), 32'(done), 32'd0);
      step();
    end
    check("rmid acc before", 32'(acc), 32'h27);
    check("rmid busy before", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rmid acc", 32'(acc), 32'd0);
    check("rmid busy", 32'(busy), 32'd0);
    check("rmid done", 32'(done), 32'd0);
    check("rmid ready", 32'(bus.instr_ready), 32'd1);
    check("rmid alu_op", 32'(alu_op), 32'(kPASS_A));
    step();
    check("rmid held acc", 32'(acc), 32'd0);
    #2;
    reset_n = 1'b1;
    step();
    check("rmid idle done", 32'(done), 32'd0);
    run_instr("post_rst", kPASS_B, 8'h11, 4'd0, 8'h11, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
